// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS-style fetch front end.
package mips_fetch_pkg;

  localparam int PC_WIDTH_DEF    = 32;
  localparam int FETCH_LAT_DEF   = 2;
  localparam int JUMP_REGION_MSB = 28;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    VALID
  } fetch_state_t;

endpackage

// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit <-> instruction memory / decode bundle.
// Optional ADDR_RANGE_CHECK_EN adds the addr_fault flag.
interface pc_fetch_unit_if #(
  parameter int PC_WIDTH = 32,
  parameter int AW       = 3
);
  logic                start;
  logic [AW-1:0]       read_address;
  logic [PC_WIDTH-1:0] pc;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic                fetch_valid;
  logic                fetch_ready;
  logic                stall;
  logic                branch_taken;
  logic [15:0]         branch_offset;
  logic                jump;
  logic [25:0]         jump_target;
`ifdef ADDR_RANGE_CHECK_EN
  logic                addr_fault;
`endif

  modport master (
    input  start, fetch_ready, stall, branch_taken, branch_offset, jump, jump_target,
    output read_address, pc, pc_plus4, fetch_valid
`ifdef ADDR_RANGE_CHECK_EN
    , output addr_fault
`endif
  );

  modport slave (
    output start, fetch_ready, stall, branch_taken, branch_offset, jump, jump_target,
    input  read_address, pc, pc_plus4, fetch_valid
`ifdef ADDR_RANGE_CHECK_EN
    , input addr_fault
`endif
  );

endinterface

// File: rtl/pc_fetch_unit_pc_next_calc.sv
// Next-PC selection: jump beats branch, branch beats sequential.
module pc_next_calc
  import mips_fetch_pkg::*;
#(
  parameter int PC_WIDTH = PC_WIDTH_DEF
) (
  input  logic [PC_WIDTH-1:0] pc_plus4,
  input  logic                jump,
  input  logic [25:0]         jump_target,
  input  logic                branch_taken,
  input  logic [15:0]         branch_offset,
  output logic [PC_WIDTH-1:0] next_pc
);

  logic [PC_WIDTH-1:0] branch_disp;

  assign branch_disp = {{(PC_WIDTH-18){branch_offset[15]}}, branch_offset, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump)
      next_pc = {pc_plus4[PC_WIDTH-1:JUMP_REGION_MSB], jump_target, 2'b00};
    else if (branch_taken)
      next_pc = pc_plus4 + branch_disp;
  end

endmodule

// File: rtl/pc_fetch_unit.sv
// PC register and fetch sequencer in front of a fixed-latency instruction memory.
// Define ADDR_RANGE_CHECK_EN to flag and freeze on out-of-range PCs via addr_fault.
module pc_fetch_unit
  import mips_fetch_pkg::*;
#(
  parameter int                     PC_WIDTH   = PC_WIDTH_DEF,
  parameter int                     IMEM_WORDS = 2,
  parameter int                     FETCH_LAT  = FETCH_LAT_DEF,
  parameter logic [PC_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic            clk,
  input  logic            rst,
  pc_fetch_unit_if.master bus
);

  localparam int AW = $clog2(IMEM_WORDS*4);
  localparam int CW = (FETCH_LAT > 1) ? $clog2(FETCH_LAT) : 1;
  localparam logic [CW-1:0] CNT_LOAD = CW'(FETCH_LAT-1);

  fetch_state_t        state;
  logic [CW-1:0]       cnt;
  logic [PC_WIDTH-1:0] pc_q;
  logic [PC_WIDTH-1:0] pc_plus4;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] next_aligned;
  logic                valid_q;
  logic                accept;

  assign pc_plus4     = pc_q + PC_WIDTH'(4);
  assign next_aligned = next_pc & ~PC_WIDTH'(3);
  assign accept       = valid_q & bus.fetch_ready & ~bus.stall;

  pc_next_calc #(.PC_WIDTH(PC_WIDTH)) u_next (
    .pc_plus4      (pc_plus4),
    .jump          (bus.jump),
    .jump_target   (bus.jump_target),
    .branch_taken  (bus.branch_taken),
    .branch_offset (bus.branch_offset),
    .next_pc       (next_pc)
  );

  assign bus.pc           = pc_q;
  assign bus.pc_plus4     = pc_plus4;
  assign bus.read_address = pc_q[AW-1:0];
  assign bus.fetch_valid  = valid_q;

`ifdef ADDR_RANGE_CHECK_EN
  localparam logic [PC_WIDTH:0] IMEM_BYTES = (PC_WIDTH+1)'(IMEM_WORDS*4);
  logic fault_q;
  assign bus.addr_fault = fault_q;
`endif

  // The WAIT counter is loaded with FETCH_LAT-1 so WAIT lasts exactly FETCH_LAT cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      pc_q    <= RESET_PC;
      valid_q <= 1'b0;
`ifdef ADDR_RANGE_CHECK_EN
      fault_q <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.start)
            state <= ISSUE;
        end
        ISSUE: begin
`ifdef ADDR_RANGE_CHECK_EN
          if (!fault_q) begin
            cnt   <= CNT_LOAD;
            state <= WAIT;
          end
`else
          cnt   <= CNT_LOAD;
          state <= WAIT;
`endif
        end
        WAIT: begin
          if (cnt == '0) begin
            state   <= VALID;
            valid_q <= 1'b1;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        VALID: begin
          if (accept) begin
            pc_q    <= next_aligned;
            valid_q <= 1'b0;
            state   <= ISSUE;
`ifdef ADDR_RANGE_CHECK_EN
            fault_q <= ({1'b0, next_aligned} >= IMEM_BYTES);
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
